// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Instruction-memory request/acknowledge bus between the fetch
//            unit (master) and the instruction memory (slave).
// Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 15
);
    logic               im_req;
    logic [ADDR_W-1:0]  im_addr;
    logic               im_ack;
    logic [INSTR_W-1:0] im_data;

    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_data
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_data
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Holds the program counter, fetches
//            opcode/k8 words over a req/ack bus into an instruction register
//            and issues a one-cycle instr_valid execute strobe.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 15
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              run,
    fetch_unit_if.master           im,
    input  wire logic              jmp_en,
    input  wire logic [ADDR_W-1:0] jmp_addr,
    output logic      [6:0]        opcode,
    output logic      [7:0]        k8,
    output logic                   instr_valid,
    output logic      [ADDR_W-1:0] pc,
    output logic      [15:0]       retired
);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_REQ  = 2'd1;
    localparam logic [1:0] C_ST_EXEC = 2'd2;

    // Undecoded opcode: the decoder drives no register loads for it.
    localparam logic [6:0] C_OPCODE_RST = 7'h7F;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              im_req_q, im_req_d;
    logic              instr_valid_q, instr_valid_d;
    logic [15:0]       retired_q, retired_d;
    logic [6:0]        opcode_q, opcode_d;
    logic [7:0]        k8_q, k8_d;

    // State and output registers; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= C_ST_IDLE;
            pc_q          <= '0;
            im_req_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            retired_q     <= 16'd0;
            opcode_q      <= C_OPCODE_RST;
            k8_q          <= 8'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            im_req_q      <= im_req_d;
            instr_valid_q <= instr_valid_d;
            retired_q     <= retired_d;
            opcode_q      <= opcode_d;
            k8_q          <= k8_d;
        end
    end

    // Next-state: an outstanding fetch always completes; run only gates new ones.
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: if (run)       state_d = C_ST_REQ;
            C_ST_REQ:  if (im.im_ack) state_d = C_ST_EXEC;
            C_ST_EXEC: state_d = run ? C_ST_REQ : C_ST_IDLE;
            default:   state_d = C_ST_IDLE;
        endcase
    end

    // Output/datapath updates; req and valid are registered from the next state.
    always_comb begin
        pc_d          = pc_q;
        retired_d     = retired_q;
        opcode_d      = opcode_q;
        k8_d          = k8_q;
        im_req_d      = (state_d == C_ST_REQ);
        instr_valid_d = (state_d == C_ST_EXEC);
        // Acks seen outside REQ are spurious and must not touch the IR.
        if ((state_q == C_ST_REQ) && im.im_ack) begin
            opcode_d = im.im_data[INSTR_W-1 -: 7];
            k8_d     = im.im_data[7:0];
        end
        // Jumps are honoured only in the execute cycle.
        if (state_q == C_ST_EXEC) begin
            retired_d = retired_q + 16'd1;
            pc_d      = jmp_en ? jmp_addr : pc_q + ADDR_W'(1);
        end
    end

    // The address bus is the PC itself, so it is stable for the whole request.
    assign im.im_req   = im_req_q;
    assign im.im_addr  = pc_q;
    assign opcode      = opcode_q;
    assign k8          = k8_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign retired     = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: directed vectors, an
//            instruction memory responder and a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_EXEC  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        jmp_en;
    logic [7:0]  jmp_addr;
    logic [6:0]  opcode;
    logic [7:0]  k8;
    logic        instr_valid;
    logic [7:0]  pc;
    logic [15:0] retired;

    int total = 0;
    int bad   = 0;

    fetch_unit_if #(.ADDR_W(8), .INSTR_W(15)) im_bus ();

    fetch_unit #(.ADDR_W(8), .INSTR_W(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .im          (im_bus.master),
        .jmp_en      (jmp_en),
        .jmp_addr    (jmp_addr),
        .opcode      (opcode),
        .k8          (k8),
        .instr_valid (instr_valid),
        .pc          (pc),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory responder ----------------
    logic [14:0] mem [256];
    bit          auto_ack  = 1'b0;
    logic        man_ack   = 1'b0;
    logic [14:0] man_data  = 15'h0;
    logic [7:0]  slow_addr = 8'h04;
    int          slow_wait = 3;
    int          wcnt      = 0;

    always @(posedge clk) begin
        #1;
        if (!auto_ack) begin
            im_bus.im_ack  = man_ack;
            im_bus.im_data = man_data;
            wcnt = 0;
        end else if (im_bus.im_req) begin
            if (wcnt >= ((im_bus.im_addr == slow_addr) ? slow_wait : 0)) begin
                im_bus.im_ack  = 1'b1;
                im_bus.im_data = mem[im_bus.im_addr];
                wcnt = 0;
            end else begin
                im_bus.im_ack  = 1'b0;
                im_bus.im_data = 15'h5A5A;
                wcnt++;
            end
        end else begin
            im_bus.im_ack  = 1'b0;
            im_bus.im_data = 15'h5A5A;
            wcnt = 0;
        end
    end

    // ---------------- transaction-level model ----------------
    bit m_ok    = 1'b0;
    int m_phase = M_IDLE;
    int m_pc    = 0;
    int m_ret   = 0;
    int m_op    = 0;
    int m_k8    = 0;

    // Instruction lifecycle: wait for run, fetch until acked, execute one cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_ok    <= 1'b1;
            m_phase <= M_IDLE;
            m_pc    <= 0;
            m_ret   <= 0;
            m_op    <= 'h7F;
            m_k8    <= 0;
        end else begin
            case (m_phase)
                M_IDLE:  if (run) m_phase <= M_FETCH;
                M_FETCH: if (im_bus.im_ack === 1'b1) begin
                    m_op    <= int'(im_bus.im_data) / 256;
                    m_k8    <= int'(im_bus.im_data) % 256;
                    m_phase <= M_EXEC;
                end
                default: begin
                    m_ret   <= (m_ret + 1) % 65536;
                    m_pc    <= jmp_en ? int'(jmp_addr) : (m_pc + 1) % 256;
                    m_phase <= run ? M_FETCH : M_IDLE;
                end
            endcase
        end
    end

    // Every-cycle comparison against the model.
    bit prev_valid = 1'b0;
    always @(negedge clk) begin
        if (m_ok) begin
            chk("cyc_im_req", 32'(im_bus.im_req), 32'(m_phase == M_FETCH));
            chk("cyc_valid", 32'(instr_valid), 32'(m_phase == M_EXEC));
            if (m_phase == M_FETCH) chk("cyc_im_addr", 32'(im_bus.im_addr), 32'(m_pc));
            chk("cyc_pc", 32'(pc), 32'(m_pc));
            chk("cyc_retired", 32'(retired), 32'(m_ret));
            chk("cyc_opcode", 32'(opcode), 32'(m_op));
            chk("cyc_k8", 32'(k8), 32'(m_k8));
            if (prev_valid) chk("valid_gap", 32'(instr_valid), 32'd0);
            prev_valid = instr_valid;
        end
    end

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (instr_valid !== 1'b1 && n < 20);
        chk(name, 32'(instr_valid), 32'd1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 15'((i * 37 + 11) % 32768);
        mem[0] = 15'h0205;   // MOV A,#5
        mem[1] = 15'h0603;   // ADD A,#3
        mem[3] = 15'h0A11;
        mem[4] = 15'h1522;

        // Reset with run and ack asserted: reset wins.
        rst_n = 1'b0; run = 1'b1; jmp_en = 1'b0; jmp_addr = 8'h00;
        man_ack = 1'b1; man_data = 15'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_req", 32'(im_bus.im_req), 32'h0);
        chk("rst_opcode", 32'(opcode), 32'h7F);
        chk("rst_k8", 32'(k8), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_retired", 32'(retired), 32'h0);

        // Zero-wait stream: valid two cycles after run is sampled.
        auto_ack = 1'b1; rst_n = 1'b1;
        @(negedge clk);
        chk("zw_req0", 32'(im_bus.im_req), 32'h1);
        chk("zw_addr0", 32'(im_bus.im_addr), 32'h0);
        @(negedge clk);
        chk("zw_valid0", 32'(instr_valid), 32'h1);
        chk("zw_op0", 32'(opcode), 32'h02);
        chk("zw_k80", 32'(k8), 32'h05);
        @(negedge clk);
        chk("zw_gap", 32'(instr_valid), 32'h0);
        @(negedge clk);
        chk("zw_valid1", 32'(instr_valid), 32'h1);
        chk("zw_op1", 32'(opcode), 32'h06);
        chk("zw_k81", 32'(k8), 32'h03);
        run = 1'b0;
        @(negedge clk);
        chk("zw_pc", 32'(pc), 32'h2);
        chk("zw_retired", 32'(retired), 32'h2);
        chk("zw_idle_req", 32'(im_bus.im_req), 32'h0);

        // Wait states at pc=4: request held 4 cycles, IR unchanged until ack.
        run = 1'b1;
        wait_valid("ws_exec2");
        chk("ws_pc2", 32'(pc), 32'h2);
        wait_valid("ws_exec3");
        chk("ws_op3", 32'(opcode), 32'h0A);
        chk("ws_k83", 32'(k8), 32'h11);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("ws_req_held", 32'(im_bus.im_req), 32'h1);
            chk("ws_addr_held", 32'(im_bus.im_addr), 32'h4);
            chk("ws_op_stale", 32'(opcode), 32'h0A);
        end
        @(negedge clk);
        chk("ws_valid4", 32'(instr_valid), 32'h1);
        chk("ws_op4", 32'(opcode), 32'h15);
        chk("ws_k84", 32'(k8), 32'h22);

        // Jump to 0xFF, ignored jump during REQ, then wrap to 0.
        jmp_en = 1'b1; jmp_addr = 8'hFF;
        @(negedge clk);
        chk("jmp_addr_ff", 32'(im_bus.im_addr), 32'hFF);
        jmp_addr = 8'h77;
        @(negedge clk);
        chk("jmp_exec_ff", 32'(instr_valid), 32'h1);
        jmp_en = 1'b0;
        @(negedge clk);
        chk("wrap_pc", 32'(pc), 32'h0);
        chk("wrap_addr", 32'(im_bus.im_addr), 32'h0);
        @(negedge clk);
        chk("jmp40_exec", 32'(instr_valid), 32'h1);
        jmp_en = 1'b1; jmp_addr = 8'h40;
        slow_addr = 8'h41; slow_wait = 2;
        @(negedge clk);
        chk("jmp40_addr", 32'(im_bus.im_addr), 32'h40);
        jmp_en = 1'b0;

        // Run dropped in the 2nd REQ cycle; ack in the 3rd still completes.
        @(negedge clk);
        chk("rd_exec40", 32'(instr_valid), 32'h1);
        @(negedge clk);
        chk("rd_req_c1", 32'(im_bus.im_addr), 32'h41);
        @(negedge clk);
        chk("rd_req_c2", 32'(im_bus.im_req), 32'h1);
        run = 1'b0;
        @(negedge clk);
        chk("rd_req_c3", 32'(im_bus.im_req), 32'h1);
        @(negedge clk);
        chk("rd_exec41", 32'(instr_valid), 32'h1);
        @(negedge clk);
        chk("rd_idle_req", 32'(im_bus.im_req), 32'h0);
        chk("rd_pc", 32'(pc), 32'h42);
        chk("rd_retired", 32'(retired), 32'd9);
        @(negedge clk);
        chk("rd_still_idle", 32'(im_bus.im_req), 32'h0);

        // Reset in REQ, ack for the dropped request arrives in the next cycle.
        auto_ack = 1'b0; man_ack = 1'b0; run = 1'b1;
        @(negedge clk);
        chk("rm_req", 32'(im_bus.im_req), 32'h1);
        chk("rm_addr", 32'(im_bus.im_addr), 32'h42);
        rst_n = 1'b0; run = 1'b0; man_ack = 1'b1; man_data = 15'h3F3F;
        @(negedge clk);
        chk("rm_req_low", 32'(im_bus.im_req), 32'h0);
        rst_n = 1'b1; man_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rm_valid", 32'(instr_valid), 32'h0);
            chk("rm_pc", 32'(pc), 32'h0);
            chk("rm_opcode", 32'(opcode), 32'h7F);
            chk("rm_retired", 32'(retired), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
